// File: rtl/ysyx_25020047_defs.sv
// rtl/ysyx_25020047_defs.sv - shared inst_type encodings and LSU state encoding
// The one-hot type constants are shared with the decoder and WBU.
package ysyx_25020047_defs;

  localparam logic [31:0] ITYPE_LW  = 32'h0000_0020;
  localparam logic [31:0] ITYPE_LBU = 32'h0000_0040;
  localparam logic [31:0] ITYPE_SW  = 32'h0000_0080;
  localparam logic [31:0] ITYPE_SB  = 32'h0000_0100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_mem(input logic [31:0] itype);
    return (itype == ITYPE_LW) || (itype == ITYPE_LBU) ||
           (itype == ITYPE_SW) || (itype == ITYPE_SB);
  endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_lane.sv
// rtl/ysyx_25020047_lsu_lane.sv - byte-lane mask/wdata generation and load extraction
// Purely combinational; the request side sees the incoming instruction, the load side the latched one.
module ysyx_25020047_lsu_lane
  import ysyx_25020047_defs::*;
(
  input  logic [31:0] req_itype,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_sdata,
  output logic        req_wen,
  output logic [3:0]  req_wmask,
  output logic [31:0] req_wdata,
  input  logic [31:0] ld_itype,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  always_comb begin
    req_wen   = 1'b0;
    req_wmask = 4'hF;
    req_wdata = '0;
    if (req_itype == ITYPE_SB) begin
      req_wen   = 1'b1;
      req_wmask = 4'b0001 << req_off;
      req_wdata = {4{req_sdata[7:0]}};
    end else if (req_itype == ITYPE_SW) begin
      req_wen   = 1'b1;
      req_wdata = req_sdata;
    end
  end

  // Stores and anything else return zero so write-back never sees stale bus data.
  always_comb begin
    ld_data = '0;
    if (ld_itype == ITYPE_LW) begin
      ld_data = rdata;
    end else if (ld_itype == ITYPE_LBU) begin
      case (ld_off)
        2'd0:    ld_data = {24'b0, rdata[7:0]};
        2'd1:    ld_data = {24'b0, rdata[15:8]};
        2'd2:    ld_data = {24'b0, rdata[23:16]};
        default: ld_data = {24'b0, rdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// rtl/ysyx_25020047_lsu.sv - non-pipelined load/store unit between EXU and WBU
// Optional LSU_MISALIGN_CHECK_EN adds lsu_err and traps misaligned lw/sw without a memory access.
module ysyx_25020047_lsu
  import ysyx_25020047_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic              lsu_err,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] memdata
);

  lsu_state_e        state_q, state_d;
  logic [31:0]       itype_q, itype_d;
  logic [1:0]        off_q, off_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] memdata_q, memdata_d;
`ifdef LSU_MISALIGN_CHECK_EN
  logic              lsu_err_q, lsu_err_d;
`endif

  logic              req_wen;
  logic [3:0]        req_wmask;
  logic [31:0]       req_wdata;
  logic [31:0]       ld_data;
  logic              misalign;

  ysyx_25020047_lsu_lane u_lane (
    .req_itype (inst_type),
    .req_off   (addr[1:0]),
    .req_sdata (store_data),
    .req_wen   (req_wen),
    .req_wmask (req_wmask),
    .req_wdata (req_wdata),
    .ld_itype  (itype_q),
    .ld_off    (off_q),
    .rdata     (mem_rdata),
    .ld_data   (ld_data)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((inst_type == ITYPE_LW) || (inst_type == ITYPE_SW)) && (addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    itype_d         = itype_q;
    off_d           = off_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_wen_d       = mem_wen_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wmask_d     = mem_wmask_q;
    out_valid_d     = out_valid_q;
    memdata_d       = memdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
    lsu_err_d       = lsu_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          itype_d = inst_type;
          off_d   = addr[1:0];
          if (is_mem(inst_type) && !misalign) begin
            state_d         = S_REQ;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = {addr[ADDR_W-1:2], 2'b00};
            mem_wen_d       = req_wen;
            mem_wdata_d     = req_wdata;
            mem_wmask_d     = req_wmask;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            memdata_d   = '0;
`ifdef LSU_MISALIGN_CHECK_EN
            lsu_err_d   = misalign;
`endif
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          // A response in the acceptance cycle completes the access immediately.
          if (mem_resp_valid) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            memdata_d   = ld_data;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          memdata_d   = ld_data;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
          lsu_err_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      itype_q         <= '0;
      off_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
      out_valid_q     <= 1'b0;
      memdata_q       <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      lsu_err_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      itype_q         <= itype_d;
      off_q           <= off_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_wen_q       <= mem_wen_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      out_valid_q     <= out_valid_d;
      memdata_q       <= memdata_d;
`ifdef LSU_MISALIGN_CHECK_EN
      lsu_err_q       <= lsu_err_d;
`endif
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign out_valid     = out_valid_q;
  assign memdata       = memdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign lsu_err       = lsu_err_q;
`endif

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// tb/tb_ysyx_25020047_lsu.sv - directed self-checking bench for ysyx_25020047_lsu
// Covers LSU_MISALIGN_CHECK_EN when defined, aligned-word fallback otherwise.
module tb_ysyx_25020047_lsu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst_type;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] memdata;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        lsu_err;
`endif

  int errors = 0;
  int checks = 0;

  ysyx_25020047_lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .inst_type      (inst_type),
    .addr           (addr),
    .store_data     (store_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
`ifdef LSU_MISALIGN_CHECK_EN
    .lsu_err        (lsu_err),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .memdata        (memdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] it, input logic [31:0] a, input logic [31:0] sd);
    in_valid   = 1'b1;
    inst_type  = it;
    addr       = a;
    store_data = sd;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; inst_type = '0; addr = '0; store_data = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_memdata", memdata, 32'd0);
    check("rst_mem_wmask", {28'b0, mem_wmask}, 32'd0);
    rst_n = 1'b1;
    tick();

    // non-memory: out_valid one cycle after accept
    issue(32'h1, 32'h8000_0004, 32'hFFFF_FFFF);
    check("nm_out_valid", {31'b0, out_valid}, 32'd1);
    check("nm_memdata", memdata, 32'd0);
    check("nm_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("nm_in_ready", {31'b0, in_ready}, 32'd0);
    retire();
    check("nm_back_idle", {31'b0, in_ready}, 32'd1);
    check("nm_out_clr", {31'b0, out_valid}, 32'd0);

    // lbu with stalled ready; responses during the stall must be ignored
    issue(32'h40, 32'h8000_0003, 32'h0);
    mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      check("lbu_req_valid", {31'b0, mem_req_valid}, 32'd1);
      check("lbu_addr_hold", mem_addr, 32'h8000_0000);
      check("lbu_no_out", {31'b0, out_valid}, 32'd0);
      tick();
    end
    check("lbu_wen", {31'b0, mem_wen}, 32'd0);
    check("lbu_wmask", {28'b0, mem_wmask}, 32'hF);
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("lbu_wait_req", {31'b0, mem_req_valid}, 32'd0);
    check("lbu_wait_out", {31'b0, out_valid}, 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'hA1B2_C3D4;
    tick();
    mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    check("lbu_out_valid", {31'b0, out_valid}, 32'd1);
    check("lbu_memdata", memdata, 32'h0000_00A1);
    retire();

    // sb to lane 2
    issue(32'h100, 32'h8000_0002, 32'h1234_5678);
    check("sb_wmask", {28'b0, mem_wmask}, 32'h4);
    check("sb_wdata", mem_wdata, 32'h7878_7878);
    check("sb_wen", {31'b0, mem_wen}, 32'd1);
    check("sb_addr", mem_addr, 32'h8000_0000);
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    check("sb_out_valid", {31'b0, out_valid}, 32'd1);
    check("sb_memdata", memdata, 32'd0);
    retire();

    // lw with ready+response together, then WBU back-pressure
    issue(32'h20, 32'h8000_0010, 32'h0);
    check("lw_req_valid", {31'b0, mem_req_valid}, 32'd1);
    check("lw_addr", mem_addr, 32'h8000_0010);
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_req_ready = 1'b0; mem_rdata = 32'h0;
    check("lw_out_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("lw_memdata_hold", memdata, 32'hDEAD_BEEF);
      check("lw_in_ready_low", {31'b0, in_ready}, 32'd0);
      tick();
    end
    mem_resp_valid = 1'b0;
    retire();
    check("lw_idle", {31'b0, in_ready}, 32'd1);

    // reset while waiting for a response
    issue(32'h20, 32'h8000_0020, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("wr_pre_memdata", memdata, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    check("ar_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("ar_mem_addr", mem_addr, 32'd0);
    check("ar_memdata", memdata, 32'd0);
    check("ar_out_valid", {31'b0, out_valid}, 32'd0);
    check("ar_in_ready", {31'b0, in_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_resp_valid = 1'b0;
    check("ar_late_resp_out", {31'b0, out_valid}, 32'd0);
    check("ar_late_memdata", memdata, 32'd0);
    check("ar_idle", {31'b0, in_ready}, 32'd1);

`ifdef LSU_MISALIGN_CHECK_EN
    issue(32'h80, 32'h8000_0001, 32'hCAFE_F00D);
    check("mis_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("mis_out_valid", {31'b0, out_valid}, 32'd1);
    check("mis_lsu_err", {31'b0, lsu_err}, 32'd1);
    check("mis_memdata", memdata, 32'd0);
    retire();
    check("mis_err_clr", {31'b0, lsu_err}, 32'd0);
`else
    issue(32'h80, 32'h8000_0001, 32'hCAFE_F00D);
    check("sw_req_valid", {31'b0, mem_req_valid}, 32'd1);
    check("sw_addr", mem_addr, 32'h8000_0000);
    check("sw_wmask", {28'b0, mem_wmask}, 32'hF);
    check("sw_wdata", mem_wdata, 32'hCAFE_F00D);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    check("sw_out_valid", {31'b0, out_valid}, 32'd1);
    check("sw_memdata", memdata, 32'd0);
    retire();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
